// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronised, debounced active-low key with press/release pulses and en_buz toggle.
// Define KEY_LONG_PRESS_EN to add the key_long hold pulse (which also silences en_buz).
module key_debounce #(
  parameter int unsigned DEB_MAX  = 1_000_000,
  parameter int unsigned LONG_MAX = 100_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic en_buz
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_DEB   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] RELEASE_DEB = 2'd3;

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_MAX - 1);
  localparam int unsigned      CNT_NEED = (DEB_MAX > LONG_MAX) ? DEB_MAX : LONG_MAX + 1;

  // The long-press counter parks at LONG_MAX, so that value must be representable.
  if ($clog2(CNT_NEED) > CNT_W) begin : g_cnt_w_too_small
    $error("key_debounce: CNT_W too narrow for DEB_MAX/LONG_MAX");
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_MAX - 1);
`endif

  logic             sync1_q, sync2_q;
  logic             k_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             en_buz_q, en_buz_d;

  assign k_s = ~sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    en_buz_d    = en_buz_q;
    case (state_q)
      IDLE: begin
        if (k_s) begin
          state_d = PRESS_DEB;
          cnt_d   = '0;
        end
      end
      PRESS_DEB: begin
        if (!k_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_TERM) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          en_buz_d    = ~en_buz_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!k_s) begin
          state_d = RELEASE_DEB;
          cnt_d   = '0;
        end
`ifdef KEY_LONG_PRESS_EN
        // Step once past LONG_TERM and park there: one key_long per hold.
        else if (cnt_q < LONG_TERM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == LONG_TERM) begin
          cnt_d    = cnt_q + CNT_W'(1);
          long_d   = 1'b1;
          en_buz_d = 1'b0;
        end
`endif
      end
      RELEASE_DEB: begin
        if (k_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_TERM) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      en_buz_q    <= 1'b0;
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      en_buz_q    <= en_buz_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign en_buz      = en_buz_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce (DEB_MAX=10, LONG_MAX=50).
module tb_key_debounce;

  logic clk;
  logic rst_n;
  logic key_n;
  logic key_state;
  logic key_press;
  logic key_release;
  logic key_long;
  logic en_buz;

  int errors = 0;
  int checks = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int long_cnt = 0;
  int overlap_cnt = 0;

  key_debounce #(
    .DEB_MAX (10),
    .LONG_MAX(50),
    .CNT_W   (27)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .en_buz     (en_buz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      press_cnt   += int'(key_press);
      release_cnt += int'(key_release);
      long_cnt    += int'(key_long);
      if (key_press && key_release) overlap_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pass n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with key held down.
    rst_n = 1'b0;
    key_n = 1'b0;
    step(4);
    chk("rst_state",   int'(key_state),   0);
    chk("rst_press",   int'(key_press),   0);
    chk("rst_release", int'(key_release), 0);
    chk("rst_long",    int'(key_long),    0);
    chk("rst_en_buz",  int'(en_buz),      0);

    // First sampling edge after release is edge 0; press registers on edge 12.
    rst_n = 1'b1;
    step(12);
    chk("press1_early", int'(key_press), 0);
    chk("press1_state_early", int'(key_state), 0);
    step(1);
    chk("press1_pulse", int'(key_press), 1);
    chk("press1_state", int'(key_state), 1);
    chk("press1_en_buz", int'(en_buz), 1);
    step(1);
    chk("press1_one_cycle", int'(key_press), 0);
    step(16);
    chk("press1_hold_state", int'(key_state), 1);
    chk("press1_count", press_cnt, 1);

    // Release: same latency.
    key_n = 1'b1;
    step(12);
    chk("rel1_early", int'(key_release), 0);
    chk("rel1_state_early", int'(key_state), 1);
    step(1);
    chk("rel1_pulse", int'(key_release), 1);
    chk("rel1_state", int'(key_state), 0);
    chk("rel1_en_buz", int'(en_buz), 1);
    step(1);
    chk("rel1_one_cycle", int'(key_release), 0);
    chk("rel1_count", release_cnt, 1);
    step(5);

    // Bounce: low 5, high 2, low with a steady tail.
    key_n = 1'b0;
    step(5);
    key_n = 1'b1;
    step(2);
    key_n = 1'b0;
    step(5);
    chk("bounce_no_press", press_cnt, 1);
    chk("bounce_state", int'(key_state), 0);
    step(7);
    chk("tail_early", int'(key_press), 0);
    step(1);
    chk("tail_pulse", int'(key_press), 1);
    chk("press2_en_buz", int'(en_buz), 0);
    step(1);
    chk("press2_count", press_cnt, 2);

    // Release bounce shorter than the window.
    key_n = 1'b1;
    step(3);
    key_n = 1'b0;
    step(15);
    chk("relbounce_no_release", release_cnt, 1);
    chk("relbounce_state", int'(key_state), 1);
    key_n = 1'b1;
    step(14);
    chk("rel2_count", release_cnt, 2);
    chk("rel2_state", int'(key_state), 0);
    step(3);

    // Long hold: key_long registers 50 edges after key_press.
    key_n = 1'b0;
    step(13);
    chk("press3_pulse", int'(key_press), 1);
    chk("press3_en_buz", int'(en_buz), 1);
    step(49);
    chk("long_early", int'(key_long), 0);
    step(1);
`ifdef KEY_LONG_PRESS_EN
    chk("long_pulse", int'(key_long), 1);
    chk("long_en_buz", int'(en_buz), 0);
`else
    chk("long_absent", int'(key_long), 0);
    chk("long_en_buz", int'(en_buz), 1);
`endif
    step(1);
    chk("long_one_cycle", int'(key_long), 0);
    step(10);
`ifdef KEY_LONG_PRESS_EN
    chk("long_count", long_cnt, 1);
`else
    chk("long_count", long_cnt, 0);
`endif
    chk("long_hold_state", int'(key_state), 1);

    // Asynchronous reset while held.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(key_state), 0);
    chk("midrst_en_buz", int'(en_buz), 0);
    chk("midrst_release", int'(key_release), 0);
    key_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("midrst_no_release", release_cnt, 2);
    chk("midrst_idle_state", int'(key_state), 0);
    chk("press_total", press_cnt, 3);
    chk("no_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
